sound_mailbox_fifo: RTL and testbench
=====================================

Name: sound_mailbox_fifo

Overview:
- Bidirectional main-CPU ↔ sound-CPU command mailbox; replaces the single-entry SIN/SOUT latches with two parametrised first-word-fall-through FIFOs.
- SIN carries main → sound data; SOUT carries sound → main data.
- Keeps the legacy ready-flag semantics on status bits 7/6 and the PIA PA7/PA6 inputs, and adds depth, fill levels, full flags, sticky overflow and a synchronous flush.
- Sits inside the sound subsystem, between the main-CPU 0x44xx decode and the sound-CPU SIN/SOUT decode.

Parameters:
- DATA_W, 8, mailbox data width.
- SIN_DEPTH, 4, SIN FIFO entries; power of two, ≥2.
- SOUT_DEPTH, 4, SOUT FIFO entries; power of two, ≥2.

Ports:
- clk_1_5  in  1  clock; one CPU access per cycle.
- sound_reset_n  in  1  asynchronous, active-low reset.
- main_wr  in  1  push main_wdata into SIN.
- main_wdata  in  DATA_W  main-CPU write data.
- main_rd  in  1  pop SOUT.
- main_rdata  out  DATA_W  SOUT head, or last popped value when empty.
- main_status  out  8  {sin_ne, sout_ne, sin_full, sout_full, sin_ovf, sout_ovf, 2'b00}.
- snd_wr  in  1  push snd_wdata into SOUT.
- snd_wdata  in  DATA_W  sound-CPU write data.
- snd_rd  in  1  pop SIN.
- snd_rdata  out  DATA_W  SIN head, or last popped value when empty.
- sin_ready  out  1  SIN non-empty (to PA7).
- sout_ready  out  1  SOUT non-empty (to PA6).
- sin_level  out  $clog2(SIN_DEPTH)+1  SIN occupancy.
- sout_level  out  $clog2(SOUT_DEPTH)+1  SOUT occupancy.
- mbox_clear  in  1  synchronous flush of both FIFOs and sticky flags.
- snd_irq_n  out  1  sound-CPU IRQ request, active low.

Behaviour:
- Reset (asynchronous, sound_reset_n low; overrides everything, including mid-transfer):
  - Pointers and levels = 0.
  - sin_ready, sout_ready, full flags and ovf flags = 0.
  - main_rdata and snd_rdata = 0 (the last-value registers are cleared).
  - main_status = 8'h00; snd_irq_n = 1.
- Push: on a rising edge with wr=1 and the FIFO not full, write mem[wr_ptr] and increment wr_ptr modulo DEPTH.
  - Level, ready and full flags update on the same edge; they are visible the next cycle.
- Pop: on a rising edge with rd=1 and the FIFO not empty, copy the head into the last-value register and increment rd_ptr modulo DEPTH.
- rdata is combinational: the head entry when non-empty, otherwise the last-value register. This preserves legacy "register holds last byte" reads.
- Pop on an empty FIFO: no state change, no flag set.
- Push on a full FIFO with no same-cycle pop: data is dropped and the sticky ovf flag is set.
- Push and pop in the same cycle:
  - Non-empty and not full: both occur, level unchanged.
  - Full: both occur, no overflow.
  - Empty: push only; the pop is ignored, and the pushed word becomes the head next cycle (no bypass).
- Pointers are $clog2(DEPTH) bits with wrap. Level is one bit wider; full = (level == DEPTH), ne = (level != 0).
- mbox_clear=1 on an edge: both FIFOs empty, ovf flags cleared, last-value registers kept. It has priority over a same-cycle push or pop.
- Legacy equivalence at DEPTH=1 behaviour is not required; minimum DEPTH is 2.
- Latency: write to ready flag = 1 cycle; write to visible rdata = 1 cycle.

Optional Feature:
- SOUND_MAILBOX_IRQ_EN defined:
  - snd_irq_n = ~sin_ready, registered, so it asserts low 1 cycle after the first push into an empty SIN.
  - It deasserts 1 cycle after the pop that empties SIN or after a mbox_clear.
- Not defined: snd_irq_n tied 1'b1; no extra flops.

Decomposition:
- Shared package sound_mailbox_pkg:
  - Status bit index constants STAT_SIN_NE=7, STAT_SOUT_NE=6, STAT_SIN_FULL=5, STAT_SOUT_FULL=4, STAT_SIN_OVF=3, STAT_SOUT_OVF=2.
  - Pointer-width helper function.
- One sub-module, sound_mbox_fifo (params DATA_W, DEPTH; push/pop/clear/rdata/level/full/ne/ovf), instantiated twice.
- The top level only assembles status and IRQ.

Test Plan:
- Reset, then push 8'hA5 on SIN → after 1 cycle sin_ready=1, sin_level=1, snd_rdata=8'hA5, main_status=8'h80.
- Push 8'h01..8'h04 on SIN (DEPTH 4), then 8'h05 → sin_full=1, sin_ovf=1, main_status=8'hA8; 4 pops return 01,02,03,04; then snd_rdata=8'h04, sin_ready=0.
- Full SIN with simultaneous push 8'h77 and pop → level stays 4, no ovf, 8'h77 read last after 3 more pops.
- Empty SOUT with simultaneous snd_wr 8'h3C and main_rd → no pop; next cycle sout_level=1, main_rdata=8'h3C.
- Fill both FIFOs to 2, pulse mbox_clear together with a push → levels 0, flags 0, main_status=8'h00; assert sound_reset_n low mid-burst → all outputs 0 immediately, with no clock edge needed.
- With SOUND_MAILBOX_IRQ_EN: push to empty SIN → snd_irq_n low one cycle later, high one cycle after the final pop. Without the macro: snd_irq_n constant 1.

Source files
------------

// File: rtl/sound_mailbox_pkg.sv
// -----------------------------------------------------------------------------
// sound_mailbox_pkg
// Shared constants and helpers for the main-CPU <-> sound-CPU command mailbox.
//   STAT_*  : bit positions of the flags inside main_status
//   ptr_w() : FIFO pointer width for a given depth
// -----------------------------------------------------------------------------
package sound_mailbox_pkg;

    localparam int STAT_SIN_NE    = 7;
    localparam int STAT_SOUT_NE   = 6;
    localparam int STAT_SIN_FULL  = 5;
    localparam int STAT_SOUT_FULL = 4;
    localparam int STAT_SIN_OVF   = 3;
    localparam int STAT_SOUT_OVF  = 2;

    // Depth is a power of two >= 2, so the pointer wraps naturally.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sound_mailbox_fifo_if.sv
// -----------------------------------------------------------------------------
// sound_mailbox_fifo_if
// Bus bundle between the CPU decode logic and the mailbox.
//   master : CPU side (drives main_*/snd_* strobes, write data, mbox_clear)
//   slave  : mailbox (drives read data, status, ready flags, levels, snd_irq_n)
// -----------------------------------------------------------------------------
interface sound_mailbox_fifo_if #(
    parameter int DATA_W     = 8,
    parameter int SIN_DEPTH  = 4,
    parameter int SOUT_DEPTH = 4
);
    logic                            main_wr;
    logic [DATA_W-1:0]               main_wdata;
    logic                            main_rd;
    logic [DATA_W-1:0]               main_rdata;
    logic [7:0]                      main_status;
    logic                            snd_wr;
    logic [DATA_W-1:0]               snd_wdata;
    logic                            snd_rd;
    logic [DATA_W-1:0]               snd_rdata;
    logic                            sin_ready;
    logic                            sout_ready;
    logic [$clog2(SIN_DEPTH):0]      sin_level;
    logic [$clog2(SOUT_DEPTH):0]     sout_level;
    logic                            mbox_clear;
    logic                            snd_irq_n;

    modport master (
        output main_wr, main_wdata, main_rd, snd_wr, snd_wdata, snd_rd, mbox_clear,
        input  main_rdata, main_status, snd_rdata, sin_ready, sout_ready,
               sin_level, sout_level, snd_irq_n
    );

    modport slave (
        input  main_wr, main_wdata, main_rd, snd_wr, snd_wdata, snd_rd, mbox_clear,
        output main_rdata, main_status, snd_rdata, sin_ready, sout_ready,
               sin_level, sout_level, snd_irq_n
    );
endinterface

// File: rtl/sound_mbox_fifo.sv
// -----------------------------------------------------------------------------
// sound_mbox_fifo
// First-word-fall-through FIFO used for one direction of the mailbox.
//   clk_1_5, sound_reset_n : clock, async active-low reset
//   push/wdata             : write strobe and data (dropped when full, sets ovf)
//   pop                    : remove head (ignored when empty)
//   clear                  : synchronous flush of entries and ovf; last value kept
//   rdata                  : head when non-empty, else last popped value
//   level/full/ne/ovf      : occupancy and flags
// -----------------------------------------------------------------------------
module sound_mbox_fifo
    import sound_mailbox_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int PW    = ptr_w(DEPTH)
) (
    input  logic              clk_1_5,
    input  logic              sound_reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    input  logic              clear,
    output logic [DATA_W-1:0] rdata,
    output logic [PW:0]       level,
    output logic              full,
    output logic              ne,
    output logic              ovf
);
    localparam logic [PW:0] LVL_FULL = (PW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] last_q;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       level_q;
    logic              ovf_q;
    logic              do_push;
    logic              do_pop;

    assign ne      = (level_q != '0);
    assign full    = (level_q == LVL_FULL);
    // A pop on a full FIFO frees the slot for the same-cycle push; a pop on an
    // empty FIFO is ignored, so the pushed word only becomes head next cycle.
    assign do_pop  = pop & ne;
    assign do_push = push & (~full | pop);

    always_ff @(posedge clk_1_5 or negedge sound_reset_n) begin
        if (!sound_reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            last_q  <= '0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            if (push && !do_push) ovf_q <= 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage carries no reset; the valid window is defined by the pointers.
    always_ff @(posedge clk_1_5) begin
        if (do_push && !clear) mem[wr_ptr] <= wdata;
    end

    assign rdata = ne ? mem[rd_ptr] : last_q;
    assign level = level_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/sound_mailbox_fifo.sv
// -----------------------------------------------------------------------------
// sound_mailbox_fifo
// Main-CPU <-> sound-CPU command mailbox built from two FWFT FIFOs.
//   SIN  : main -> sound (main_wr pushes, snd_rd pops, snd_rdata reads head)
//   SOUT : sound -> main (snd_wr pushes, main_rd pops, main_rdata reads head)
// Ports: clk_1_5, sound_reset_n (async, active low), mbx (slave modport)
//   main_status = {sin_ne, sout_ne, sin_full, sout_full, sin_ovf, sout_ovf, 2'b00}
//   sin_ready/sout_ready feed PIA PA7/PA6.
// Optional: define SOUND_MAILBOX_IRQ_EN to drive snd_irq_n = registered
// ~sin_ready; otherwise snd_irq_n is tied high.
// -----------------------------------------------------------------------------
module sound_mailbox_fifo
    import sound_mailbox_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int SIN_DEPTH  = 4,
    parameter int SOUT_DEPTH = 4
) (
    input  logic                  clk_1_5,
    input  logic                  sound_reset_n,
    sound_mailbox_fifo_if.slave   mbx
);
    logic sin_full, sin_ne, sin_ovf;
    logic sout_full, sout_ne, sout_ovf;
    logic [7:0] status;

    sound_mbox_fifo #(.DATA_W(DATA_W), .DEPTH(SIN_DEPTH)) u_sin (
        .clk_1_5       (clk_1_5),
        .sound_reset_n (sound_reset_n),
        .push          (mbx.main_wr),
        .wdata         (mbx.main_wdata),
        .pop           (mbx.snd_rd),
        .clear         (mbx.mbox_clear),
        .rdata         (mbx.snd_rdata),
        .level         (mbx.sin_level),
        .full          (sin_full),
        .ne            (sin_ne),
        .ovf           (sin_ovf)
    );

    sound_mbox_fifo #(.DATA_W(DATA_W), .DEPTH(SOUT_DEPTH)) u_sout (
        .clk_1_5       (clk_1_5),
        .sound_reset_n (sound_reset_n),
        .push          (mbx.snd_wr),
        .wdata         (mbx.snd_wdata),
        .pop           (mbx.main_rd),
        .clear         (mbx.mbox_clear),
        .rdata         (mbx.main_rdata),
        .level         (mbx.sout_level),
        .full          (sout_full),
        .ne            (sout_ne),
        .ovf           (sout_ovf)
    );

    always_comb begin
        status                 = 8'h00;
        status[STAT_SIN_NE]    = sin_ne;
        status[STAT_SOUT_NE]   = sout_ne;
        status[STAT_SIN_FULL]  = sin_full;
        status[STAT_SOUT_FULL] = sout_full;
        status[STAT_SIN_OVF]   = sin_ovf;
        status[STAT_SOUT_OVF]  = sout_ovf;
    end

    assign mbx.main_status = status;
    assign mbx.sin_ready   = sin_ne;
    assign mbx.sout_ready  = sout_ne;

`ifdef SOUND_MAILBOX_IRQ_EN
    logic irq_n_q;
    always_ff @(posedge clk_1_5 or negedge sound_reset_n) begin
        if (!sound_reset_n) irq_n_q <= 1'b1;
        else                irq_n_q <= ~sin_ne;
    end
    assign mbx.snd_irq_n = irq_n_q;
`else
    assign mbx.snd_irq_n = 1'b1;
`endif

endmodule

// File: tb/tb_sound_mailbox_fifo.sv
// -----------------------------------------------------------------------------
// tb_sound_mailbox_fifo
// Scoreboard bench for sound_mailbox_fifo: expected words are queued when a
// push is driven and compared against the head when a pop is driven.
// -----------------------------------------------------------------------------
module tb_sound_mailbox_fifo;
    localparam int DATA_W     = 8;
    localparam int SIN_DEPTH  = 4;
    localparam int SOUT_DEPTH = 4;

    logic clk_1_5 = 1'b0;
    logic sound_reset_n;
    always #5 clk_1_5 = ~clk_1_5;

    sound_mailbox_fifo_if #(.DATA_W(DATA_W), .SIN_DEPTH(SIN_DEPTH), .SOUT_DEPTH(SOUT_DEPTH)) mb ();

    sound_mailbox_fifo #(.DATA_W(DATA_W), .SIN_DEPTH(SIN_DEPTH), .SOUT_DEPTH(SOUT_DEPTH)) dut (
        .clk_1_5       (clk_1_5),
        .sound_reset_n (sound_reset_n),
        .mbx           (mb.slave)
    );

    logic [DATA_W-1:0] sin_q[$];
    logic [DATA_W-1:0] sout_q[$];
    logic [DATA_W-1:0] sin_last, sout_last;
    logic              sin_ovf, sout_ovf;
    logic              m_irq_n;
    int                n_cmp = 0;
    int                n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sin_q.delete();
        sout_q.delete();
        sin_last  = '0;
        sout_last = '0;
        sin_ovf   = 1'b0;
        sout_ovf  = 1'b0;
        m_irq_n   = 1'b1;
    endtask

    task automatic check_state(input string tag);
        logic [7:0] exp_status;
        exp_status = {sin_q.size() != 0, sout_q.size() != 0,
                      sin_q.size() == SIN_DEPTH, sout_q.size() == SOUT_DEPTH,
                      sin_ovf, sout_ovf, 2'b00};
        chk({tag, ".sin_level"},  32'(mb.sin_level),  32'(sin_q.size()));
        chk({tag, ".sout_level"}, 32'(mb.sout_level), 32'(sout_q.size()));
        chk({tag, ".sin_ready"},  32'(mb.sin_ready),  32'(sin_q.size() != 0));
        chk({tag, ".sout_ready"}, 32'(mb.sout_ready), 32'(sout_q.size() != 0));
        chk({tag, ".status"},     32'(mb.main_status), 32'(exp_status));
        chk({tag, ".snd_rdata"},  32'(mb.snd_rdata),
            32'((sin_q.size() != 0) ? sin_q[0] : sin_last));
        chk({tag, ".main_rdata"}, 32'(mb.main_rdata),
            32'((sout_q.size() != 0) ? sout_q[0] : sout_last));
        chk({tag, ".irq_n"},      32'(mb.snd_irq_n), 32'(m_irq_n));
    endtask

    task automatic clear_strobes();
        mb.main_wr    = 1'b0;
        mb.main_rd    = 1'b0;
        mb.snd_wr     = 1'b0;
        mb.snd_rd     = 1'b0;
        mb.mbox_clear = 1'b0;
    endtask

    // Apply the driven strobes to the model, clock once, then check state.
    task automatic tick(input string tag);
        logic irq_nxt;
        irq_nxt = (sin_q.size() == 0);
        if (mb.mbox_clear) begin
            sin_q.delete();
            sout_q.delete();
            sin_ovf  = 1'b0;
            sout_ovf = 1'b0;
        end else begin
            if (mb.snd_rd && sin_q.size() != 0) begin
                chk({tag, ".sin_pop"}, 32'(mb.snd_rdata), 32'(sin_q[0]));
                sin_last = sin_q.pop_front();
            end
            if (mb.main_wr) begin
                if (sin_q.size() < SIN_DEPTH) sin_q.push_back(mb.main_wdata);
                else                          sin_ovf = 1'b1;
            end
            if (mb.main_rd && sout_q.size() != 0) begin
                chk({tag, ".sout_pop"}, 32'(mb.main_rdata), 32'(sout_q[0]));
                sout_last = sout_q.pop_front();
            end
            if (mb.snd_wr) begin
                if (sout_q.size() < SOUT_DEPTH) sout_q.push_back(mb.snd_wdata);
                else                            sout_ovf = 1'b1;
            end
        end
`ifdef SOUND_MAILBOX_IRQ_EN
        m_irq_n = irq_nxt;
`else
        m_irq_n = 1'b1;
`endif
        @(posedge clk_1_5);
        #1;
        clear_strobes();
        check_state(tag);
    endtask

    task automatic sin_push(input logic [7:0] d);
        mb.main_wr = 1'b1; mb.main_wdata = d; tick("sin_push");
    endtask

    task automatic sin_pop();
        mb.snd_rd = 1'b1; tick("sin_pop");
    endtask

    task automatic sout_push(input logic [7:0] d);
        mb.snd_wr = 1'b1; mb.snd_wdata = d; tick("sout_push");
    endtask

    task automatic sout_pop();
        mb.main_rd = 1'b1; tick("sout_pop");
    endtask

    initial begin
        sound_reset_n = 1'b0;
        clear_strobes();
        mb.main_wdata = '0;
        mb.snd_wdata  = '0;
        model_reset();
        #12 sound_reset_n = 1'b1;
        @(posedge clk_1_5); #1;
        check_state("reset");

        // First push lands in SIN and is readable the next cycle.
        sin_push(8'hA5);
        chk("a5_status", 32'(mb.main_status), 32'h80);
        chk("a5_rdata", 32'(mb.snd_rdata), 32'hA5);
        sin_pop();

        // Fill SIN then overflow it.
        for (int i = 1; i <= 5; i++) sin_push(8'(i));
        chk("ovf_status", 32'(mb.main_status), 32'hA8);
        repeat (4) sin_pop();
        chk("drained_rdata", 32'(mb.snd_rdata), 32'h04);
        chk("drained_ready", 32'(mb.sin_ready), 32'h0);
        sin_pop();

        // Clear the sticky flag, refill, then push+pop while full.
        mb.mbox_clear = 1'b1; tick("clear1");
        for (int i = 1; i <= 4; i++) sin_push(8'(i));
        mb.main_wr = 1'b1; mb.main_wdata = 8'h77; mb.snd_rd = 1'b1; tick("full_pushpop");
        chk("full_pp_level", 32'(mb.sin_level), 32'd4);
        chk("full_pp_ovf", 32'(mb.main_status[3]), 32'h0);
        repeat (3) sin_pop();
        chk("full_pp_last", 32'(mb.snd_rdata), 32'h77);
        sin_pop();

        // Push and pop on empty SOUT: pop ignored, no bypass.
        mb.snd_wr = 1'b1; mb.snd_wdata = 8'h3C; mb.main_rd = 1'b1; tick("empty_pushpop");
        chk("empty_pp_level", 32'(mb.sout_level), 32'd1);
        chk("empty_pp_rdata", 32'(mb.main_rdata), 32'h3C);
        sout_pop();

        // SOUT full and overflow flags.
        for (int i = 0; i < 5; i++) sout_push(8'(8'hC0 + i));
        chk("sout_ovf_status", 32'(mb.main_status), 32'h54);
        sout_pop();

        // Fill both to 2, then clear together with a push.
        mb.mbox_clear = 1'b1; tick("clear2");
        sin_push(8'h11); sin_push(8'h12);
        sout_push(8'h21); sout_push(8'h22);
        mb.mbox_clear = 1'b1; mb.main_wr = 1'b1; mb.main_wdata = 8'h99;
        mb.snd_wr = 1'b1; mb.snd_wdata = 8'h98; tick("clear_push");
        chk("clear_status", 32'(mb.main_status), 32'h00);
        chk("clear_sin_level", 32'(mb.sin_level), 32'd0);

        // Random traffic on both directions.
        for (int i = 0; i < 200; i++) begin
            mb.main_wr    = 1'($urandom_range(0, 1));
            mb.main_wdata = 8'($urandom);
            mb.snd_rd     = 1'($urandom_range(0, 1));
            mb.snd_wr     = 1'($urandom_range(0, 1));
            mb.snd_wdata  = 8'($urandom);
            mb.main_rd    = 1'($urandom_range(0, 2) == 0);
            mb.mbox_clear = 1'($urandom_range(0, 40) == 0);
            tick("rand");
        end

        // IRQ behaviour from an empty SIN.
        mb.mbox_clear = 1'b1; tick("clear3");
        tick("idle");
        sin_push(8'h5A);
        tick("irq_wait");
        sin_pop();
        tick("irq_release");

        // Asynchronous reset in the middle of a burst.
        sin_push(8'h31); sin_push(8'h32); sout_push(8'h41);
        mb.main_wr = 1'b1; mb.main_wdata = 8'h33; mb.snd_wr = 1'b1; mb.snd_wdata = 8'h42;
        #3 sound_reset_n = 1'b0;
        #1;
        model_reset();
        check_state("async_rst");
        chk("async_rst_status", 32'(mb.main_status), 32'h00);
        clear_strobes();
        @(posedge clk_1_5); #3;
        sound_reset_n = 1'b1;
        @(posedge clk_1_5); #1;
        check_state("post_rst");
        sin_push(8'h66);
        sin_pop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
